// File: rtl/mux8_rr_scheduler_if.sv
// Request/grant/beat handshake bundle between eight requesters, the scheduler and the consumer.
interface mux8_rr_scheduler_if;
    logic [7:0] req;
    logic [7:0] last;
    logic       out_ready;
    logic [3:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic [7:0] ack;

    modport master (
        output req, last, out_ready,
        input  sel, grant, out_valid, ack
    );

    modport slave (
        input  req, last, out_ready,
        output sel, grant, out_valid, ack
    );
endinterface

// File: rtl/mux8_rr_scheduler.sv
// Per-burst round-robin scheduler for the shared 8:1 datapath mux; sel=4'h8 parks the mux at zero.
// Optional MUX8_SCHED_PRIO_EN makes requester 0 strict-high-priority at every arbitration point.
module mux8_rr_scheduler #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux8_rr_scheduler_if.slave   bus
);

    typedef enum logic { IDLE, BUSY } state_t;

    state_t             state_p0, state_nx;
    logic [3:0]         sel_p0, sel_nx;
    logic [7:0]         grant_p0, grant_nx;
    logic [2:0]         ptr_p0, ptr_nx;
    logic [CNT_W-1:0]   beat_cnt_p0, beat_cnt_nx;

    logic [2:0]         g;
    logic               busy;
    logic               cur_req;
    logic               cur_last;
    logic               valid;
    logic               beat;
    logic               cnt_hit;
    logic               burst_end;
    logic               arb;
    logic [3:0]         win;
    logic               win_upd_ptr;

    // Returns {found, index} of the first set bit after p, wrapping 7->0; p itself ranks last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'h0;
        for (int k = 8; k >= 1; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign busy     = (state_p0 == BUSY);
    assign g        = sel_p0[2:0];
    assign cur_req  = |(bus.req & grant_p0);
    assign cur_last = bus.last[g];
    assign valid    = busy & cur_req & ~rst;
    assign beat     = valid & bus.out_ready;
    assign cnt_hit  = (beat_cnt_p0 + CNT_W'(1)) == CNT_W'(MAX_BURST);
    assign burst_end = busy & (~cur_req | (beat & (cur_last | cnt_hit)));
    assign arb      = ~busy | burst_end;

    always_comb begin
        win         = 4'h0;
        win_upd_ptr = 1'b1;
`ifdef MUX8_SCHED_PRIO_EN
        // Priority grants leave ptr alone so 1..7 keep their rotation.
        if (bus.req[0]) begin
            win         = 4'b1000;
            win_upd_ptr = 1'b0;
        end else begin
            win = rr_pick(bus.req & 8'hFE, ptr_p0);
        end
`else
        win = rr_pick(bus.req, ptr_p0);
`endif
    end

    // Next-state and outputs
    always_comb begin
        state_nx    = state_p0;
        sel_nx      = sel_p0;
        grant_nx    = grant_p0;
        ptr_nx      = ptr_p0;
        beat_cnt_nx = beat_cnt_p0;
        if (arb) begin
            if (win[3]) begin
                state_nx    = BUSY;
                sel_nx      = {1'b0, win[2:0]};
                grant_nx    = 8'h01 << win[2:0];
                beat_cnt_nx = '0;
                if (win_upd_ptr) ptr_nx = win[2:0];
            end else begin
                state_nx    = IDLE;
                sel_nx      = 4'h8;
                grant_nx    = 8'h00;
            end
        end else if (beat) begin
            beat_cnt_nx = beat_cnt_p0 + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= IDLE;
            sel_p0      <= 4'h8;
            grant_p0    <= 8'h00;
            ptr_p0      <= 3'd7;
            beat_cnt_p0 <= '0;
        end else begin
            state_p0    <= state_nx;
            sel_p0      <= sel_nx;
            grant_p0    <= grant_nx;
            ptr_p0      <= ptr_nx;
            beat_cnt_p0 <= beat_cnt_nx;
        end
    end

    assign bus.sel       = sel_p0;
    assign bus.grant     = grant_p0;
    assign bus.out_valid = valid;
    assign bus.ack       = grant_p0 & {8{beat}};

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed-vector bench for mux8_rr_scheduler with hand-computed per-cycle expectations.
module tb_mux8_rr_scheduler;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mux8_rr_scheduler_if bus ();

    mux8_rr_scheduler #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle at the falling edge, then advances to just past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] s, input logic [7:0] g,
                       input logic v, input logic [7:0] a);
        @(negedge clk);
        chk({tag, ".sel"},   32'(bus.sel),       32'(s));
        chk({tag, ".grant"}, 32'(bus.grant),     32'(g));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".ack"},   32'(bus.ack),       32'(a));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] gi;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req = 8'h00;
        bus.last = 8'h00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) cyc("idle", 4'h8, 8'h00, 1'b0, 8'h00);

        // Two requesters alternate 4-beat bursts with no gap; ptr ends at 2
        bus.req = 8'h06;
        bus.out_ready = 1'b1;
        cyc("rr_arb", 4'h8, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            gi = ((i / 4) % 2 == 0) ? 3'd1 : 3'd2;
            cyc("rr_beat", {1'b0, gi}, 8'h01 << gi, 1'b1, 8'h01 << gi);
        end
        cyc("rr_beat", 4'h2, 8'h04, 1'b1, 8'h04);
        bus.req = 8'h00;
        cyc("rr_drop", 4'h2, 8'h04, 1'b0, 8'h00);
        cyc("rr_idle", 4'h8, 8'h00, 1'b0, 8'h00);

        // last on beat 2 with a stall between beats; ptr ends at 3
        bus.req = 8'h08;
        cyc("last_arb", 4'h8, 8'h00, 1'b0, 8'h00);
        cyc("last_b1", 4'h3, 8'h08, 1'b1, 8'h08);
        bus.out_ready = 1'b0;
        cyc("last_stall", 4'h3, 8'h08, 1'b1, 8'h00);
        bus.out_ready = 1'b1;
        bus.last = 8'h08;
        cyc("last_b2", 4'h3, 8'h08, 1'b1, 8'h08);
        bus.req = 8'h00;
        bus.last = 8'h00;
        cyc("last_drop", 4'h3, 8'h08, 1'b0, 8'h00);
        cyc("last_idle", 4'h8, 8'h00, 1'b0, 8'h00);

        // Abort: requester 5 drops after one beat, requester 6 takes over; ptr ends at 6
        bus.req = 8'h60;
        cyc("abort_arb", 4'h8, 8'h00, 1'b0, 8'h00);
        cyc("abort_b1", 4'h5, 8'h20, 1'b1, 8'h20);
        bus.req = 8'h40;
        cyc("abort_drop", 4'h5, 8'h20, 1'b0, 8'h00);
        cyc("abort_next", 4'h6, 8'h40, 1'b1, 8'h40);
        bus.req = 8'h00;
        cyc("abort_end", 4'h6, 8'h40, 1'b0, 8'h00);
        cyc("abort_idle", 4'h8, 8'h00, 1'b0, 8'h00);

        // Reset mid-burst on requester 2, then all request: 0 wins first
        bus.req = 8'h04;
        cyc("rst_arb", 4'h8, 8'h00, 1'b0, 8'h00);
        cyc("rst_b1", 4'h2, 8'h04, 1'b1, 8'h04);
        rst = 1'b1;
        cyc("rst_cycle", 4'h2, 8'h04, 1'b0, 8'h00);
        rst = 1'b0;
        bus.req = 8'hFF;
        cyc("rst_after", 4'h8, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc("rst_g0", 4'h0, 8'h01, 1'b1, 8'h01);
        cyc("rst_g1", 4'h1, 8'h02, 1'b1, 8'h02);
        bus.req = 8'h00;
        cyc("rst_end", 4'h1, 8'h02, 1'b0, 8'h00);
        cyc("rst_idle", 4'h8, 8'h00, 1'b0, 8'h00);

        // ptr is 1 here; requesters 0 and 7 both request
        bus.req = 8'h81;
        cyc("mix_arb", 4'h8, 8'h00, 1'b0, 8'h00);
`ifdef MUX8_SCHED_PRIO_EN
        for (int i = 0; i < 12; i++) cyc("prio_g0", 4'h0, 8'h01, 1'b1, 8'h01);
        bus.req = 8'h80;
        cyc("prio_drop", 4'h0, 8'h01, 1'b0, 8'h00);
        cyc("prio_g7", 4'h7, 8'h80, 1'b1, 8'h80);
        bus.req = 8'h00;
        cyc("prio_end", 4'h7, 8'h80, 1'b0, 8'h00);
`else
        for (int i = 0; i < 4; i++) cyc("mix_g7", 4'h7, 8'h80, 1'b1, 8'h80);
        for (int i = 0; i < 4; i++) cyc("mix_g0", 4'h0, 8'h01, 1'b1, 8'h01);
        cyc("mix_g7b", 4'h7, 8'h80, 1'b1, 8'h80);
        bus.req = 8'h00;
        cyc("mix_end", 4'h7, 8'h80, 1'b0, 8'h00);
`endif
        cyc("mix_idle", 4'h8, 8'h00, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
